clk_test: RTL and testbench

CLK_TEST -- requirements
Module: clk_test

---
 rtl/clk_test.sv | 70 +++++++
 tb/tb_clk_test.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_test.sv
// Purpose: measures the frequency of an asynchronous sysclk by counting its rising edges over a fixed clk window.
// Latency: a sysclk rise is counted about 3 clk cycles after it arrives; the result is registered one cycle after the window closes.
// Backpressure: none; freq_update is a one-cycle strobe and snes_sysclk_freq holds until the next window completes.
//
// Ports:
//   clk              system clock; every flop in this block runs on its rising edge
//   rst_n            synchronous active-low reset
//   sysclk           clock under measurement, sampled as plain data
//   snes_sysclk_freq rising-edge count of the last completed window (saturates at 32'hFFFFFFFF)
//   freq_update      one-cycle pulse, coincident with a new snes_sysclk_freq value
module clk_test #(
  parameter logic [31:0] GATE_CYCLES = 32'd96_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sysclk,
  output logic [31:0] snes_sysclk_freq,
  output logic        freq_update
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 32'd1);

  logic          s1;
  logic          s2;
  logic          s3;
  logic          edge_det;
  logic [GW-1:0] gate_cnt;
  logic [31:0]   edge_cnt;
  logic          terminal;
  logic [32:0]   edge_sum;
  logic [31:0]   window_total;

  // s1/s2 resolve metastability; s3 only remembers the previous synchronized level.
  assign edge_det = s2 & ~s3;
  assign terminal = (gate_cnt == GATE_LAST);

  // The terminal cycle's own edge goes into the closing window, so the
  // counter can be cleared on that same cycle without dropping an edge.
  assign edge_sum     = {1'b0, edge_cnt} + {32'd0, edge_det};
  assign window_total = edge_sum[32] ? 32'hFFFF_FFFF : edge_sum[31:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1               <= 1'b0;
      s2               <= 1'b0;
      s3               <= 1'b0;
      gate_cnt         <= '0;
      edge_cnt         <= '0;
      snes_sysclk_freq <= '0;
      freq_update      <= 1'b0;
    end else begin
      s1          <= sysclk;
      s2          <= s1;
      s3          <= s2;
      freq_update <= terminal;
      if (terminal) begin
        gate_cnt         <= '0;
        edge_cnt         <= '0;
        snes_sysclk_freq <= window_total;
      end else begin
        gate_cnt <= gate_cnt + GW'(1);
        if (edge_det && (edge_cnt != 32'hFFFF_FFFF)) begin
          edge_cnt <= edge_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_test.sv
// Purpose: self-checking bench for clk_test with a 100-cycle window.
// Latency: reference compares every cycle against a waveform-level edge count.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_clk_test;

  localparam int G    = 100;
  localparam int MAXC = 20000;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        sysclk = 1'b0;
  logic [31:0] snes_sysclk_freq;
  logic        freq_update;

  clk_test #(.GATE_CYCLES(32'd100)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sysclk           (sysclk),
    .snes_sysclk_freq (snes_sysclk_freq),
    .freq_update      (freq_update)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Waveform record: sysclk level and reset seen at each clk rising edge.
  int cyc      = 0;
  int last_rst = 0;
  bit cap [0:MAXC-1];

  always @(posedge clk) begin
    if (cyc < MAXC - 1) begin
      cyc           <= cyc + 1;
      cap[cyc + 1]  <= sysclk;
      if (!rst_n) last_rst <= cyc + 1;
    end
  end

  // Level seen by the detector; anything sampled at or before the latest reset reads as low.
  function automatic bit eff(input int p);
    return (p > last_rst) ? cap[p] : 1'b0;
  endfunction

  // Rising transitions of the sampled waveform whose detection lands inside
  // the window that closed at edge u (detection trails sampling by 2 edges).
  function automatic logic [31:0] model_count(input int u);
    int n;
    n = 0;
    for (int p = u - G - 1; p <= u - 2; p++) begin
      if (eff(p) && !eff(p - 1)) n++;
    end
    return 32'(n);
  endfunction

  // Continuous monitor against the reference.
  bit          chk_en = 1'b0;
  bit          exp_upd;
  logic [31:0] held = '0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (cyc == last_rst) held = '0;
      exp_upd = (cyc > last_rst) && (((cyc - last_rst) % G) == 0);
      chk("mon_upd", {31'd0, freq_update}, {31'd0, exp_upd});
      if (exp_upd) held = model_count(cyc);
      chk("mon_freq", snes_sysclk_freq, held);
    end
  end

  // sysclk generator: 0 constant, 1 square wave, 2 random run lengths.
  int mode     = 0;
  bit cval     = 1'b0;
  int per      = 4;
  int ph       = 0;
  int run_left = 0;

  initial forever begin
    @(posedge clk);
    #1;
    case (mode)
      0: sysclk = cval;
      1: begin
        sysclk = ((ph % per) < (per / 2));
        ph++;
      end
      default: begin
        if (run_left <= 0) begin
          sysclk   = ~sysclk;
          run_left = $urandom_range(1, 6);
        end
        run_left--;
      end
    endcase
  end

  task automatic wait_upd(output logic [31:0] v);
    bit seen;
    seen = 1'b0;
    v    = '0;
    for (int i = 0; i < 3 * G && !seen; i++) begin
      @(negedge clk);
      if (freq_update) begin
        seen = 1'b1;
        v    = snes_sysclk_freq;
      end
    end
    chk("upd_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] v;
  int          gap;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_freq", snes_sysclk_freq, 32'd0);
    chk("rst_upd", {31'd0, freq_update}, 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Constant low, then constant high.
    wait_upd(v); chk("lo_first", v, 32'd0);
    wait_upd(v); chk("lo_win", v, 32'd0);
    cval = 1'b1;
    wait_upd(v);
    wait_upd(v); chk("hi_win", v, 32'd0);

    // Period 4 -> 25 per window, period 2 -> 50 per window.
    cval = 1'b0; per = 4; ph = 0; mode = 1;
    wait_upd(v);
    for (int k = 0; k < 2; k++) begin wait_upd(v); chk("p4", v, 32'd25); end
    per = 2;
    wait_upd(v);
    for (int k = 0; k < 2; k++) begin wait_upd(v); chk("p2", v, 32'd50); end

    // Period 10 at every phase offset: always exactly 10.
    for (int off = 0; off < 10; off++) begin
      mode = 0; cval = 1'b0;
      do_reset(2);
      per = 10; ph = off; mode = 1;
      wait_upd(v);
      for (int k = 0; k < 2; k++) begin wait_upd(v); chk("p10", v, 32'd10); end
    end

    // Reset at gate count 50 abandons the window; next update lands G cycles after release.
    per = 4; mode = 1;
    wait_upd(v);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_freq", snes_sysclk_freq, 32'd0);
    chk("mr_upd", {31'd0, freq_update}, 32'd0);
    rst_n = 1'b1;
    gap = 0;
    for (int i = 1; i <= 3 * G && gap == 0; i++) begin
      @(negedge clk);
      if (freq_update) gap = i;
    end
    chk("mr_gap", 32'(gap), 32'd100);

    // Random run lengths with a random reset in between.
    mode = 2;
    for (int k = 0; k < 3; k++) wait_upd(v);
    repeat ($urandom_range(1, 99)) @(negedge clk);
    do_reset($urandom_range(1, 3));
    for (int k = 0; k < 4; k++) wait_upd(v);

    // Saturation: pin the edge counter at all-ones with an edge on the terminal cycle.
    mode = 0; cval = 1'b0;
    wait_upd(v);
    repeat (95) @(negedge clk);
    chk_en = 1'b0;
    force dut.edge_cnt = 32'hFFFF_FFFF;
    force dut.edge_det = 1'b1;
    wait_upd(v);
    chk("sat", v, 32'hFFFF_FFFF);
    release dut.edge_cnt;
    release dut.edge_det;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_upd(v); chk("post_sat", v, 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
